gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Self-test stage wrapped around the two-input logic-gate block.
- Upstream role: drives operand pair X/Y through all four combinations.
- Downstream role: samples the seven gate results and compares them to the truth table. Records per-gate mismatches, error count and first failing vector.
- Used as a bring-up/BIST sequencer next to the gate block.

Parameters:
SETTLE, 2, cycles each vector is held before sampling (≥1)
PASSES, 1, number of full 4-vector sweeps per run (≥1)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled only in IDLE
X  output  1  operand X to gate block (registered)
Y  output  1  operand Y to gate block (registered)
F_and, F_or, F_xor, F_not, F_nand, F_nor, F_xnor  input  1 each  gate results under test
busy  output  1  high while sweeping
done  output  1  one-cycle pulse at end of run
pass  output  1  1 = run had zero mismatches; held until next accepted start
err_count  output  ERR_W  number of failing vectors (saturating)
err_mask  output  7  sticky per-gate mismatch bits; bit0 and, 1 or, 2 xor, 3 not, 4 nand, 5 nor, 6 xnor
fail_vec  output  2  {X,Y} of first failing vector
fail_valid  output  1  fail_vec is valid

Behaviour:
- One clock (clk). Reset rst_n is asynchronous and active-low.
- Reset (async assert, any state): state=IDLE; X=Y=0; busy=done=pass=0; err_count=0; err_mask=0; fail_vec=0; fail_valid=0; internal vector/pass/settle counters=0.
- A reset mid-run aborts the run; no done pulse is issued.
- FSM states: IDLE, WAIT, DONE.
- IDLE -> WAIT on start=1:
  - clear err_count, err_mask, fail_vec, fail_valid and pass;
  - set vector=0 (X=0, Y=0), pass_idx=0, settle cnt=0.
- WAIT (busy=1):
  - cnt increments each cycle.
  - Each vector occupies exactly SETTLE cycles.
  - The check is performed on the edge ending the cycle where cnt==SETTLE-1.
- Check, using current X/Y registers:
  - expected = {~(X^Y), ~(X|Y), ~(X&Y), ~X, X^Y, X|Y, X&Y}; mismatch m = expected XOR inputs.
  - If m≠0: err_count += 1, saturating at 2^ERR_W-1 (counts vectors, not bits); err_mask |= m.
  - If m≠0 and fail_valid=0: fail_vec <= {X,Y}, fail_valid <= 1.
- Advance after the check:
  - Vector order 00, 01, 10, 11 as {X,Y}.
  - If vector==3 and pass_idx==PASSES-1: go to DONE, X=Y=0.
  - Else: vector wraps 3->0 and pass_idx++ on wrap; cnt=0; stay in WAIT.
- DONE (one cycle): done=1, busy=0, pass=(err_count==0), then go to IDLE.
- Latency: start-accept edge to done-high edge = 4·PASSES·SETTLE cycles.
- start is ignored in WAIT and DONE. With start held high, the next run begins on the IDLE cycle following DONE.
- Result outputs (pass, err_*, fail_*) hold their values after DONE until the next accepted start.

Test Plan:
1. SETTLE=2, PASSES=1, correct gate block attached; pulse start -> busy high 8 cycles, done pulses once on 9th edge; pass=1, err_count=0, err_mask=0, fail_valid=0, X/Y sequence 00,01,10,11 each for 2 cycles.
2. F_and forced 0; PASSES=3 -> mismatch only at {X,Y}=11: err_count=3, err_mask=7'b0000001, fail_vec=2'b11, fail_valid=1, pass=0.
3. F_not driven as X (inverted) -> all 4 vectors fail: err_count=4, err_mask=7'b0001000, fail_vec=2'b00.
4. start re-pulsed mid-run -> ignored, done timing unchanged. start held high -> second run begins the IDLE cycle after done, and results are cleared at its start.
5. rst_n asserted at vector 2 with an error already logged -> all outputs 0 immediately (async), no done pulse. After release, a clean start gives pass=1.
6. ERR_W=2, PASSES=2, all seven F inputs inverted -> 8 failing vectors, err_count saturates at 3, err_mask=7'h7F, fail_vec=2'b00.

Source files
------------

// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: BIST sequencer that sweeps {X,Y} through 00,01,10,11 and checks seven gate results.
// Latency: start-accept edge to done-high edge is 4*PASSES*SETTLE cycles; one-cycle DONE, then IDLE.
// Backpressure: none; start is sampled only in IDLE and ignored while sweeping or in DONE.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run request (IDLE only)
//   X, Y                  registered operands to the gate block
//   F_and..F_xnor         gate results under test
//   busy, done            sweeping flag, one-cycle end-of-run pulse
//   pass                  run had zero mismatches (held until next accepted start)
//   err_count             saturating count of failing vectors
//   err_mask              sticky per-gate mismatch bits {xnor,nor,nand,not,xor,or,and}
//   fail_vec, fail_valid  {X,Y} of first failing vector and its valid flag
module gate_sweep_checker #(
  parameter int SETTLE = 2,
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             X,
  output logic             Y,
  input  logic             F_and,
  input  logic             F_or,
  input  logic             F_xor,
  input  logic             F_not,
  input  logic             F_nand,
  input  logic             F_nor,
  input  logic             F_xnor,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [6:0]       err_mask,
  output logic [1:0]       fail_vec,
  output logic             fail_valid
);

  localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PIDX_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(SETTLE - 1);
  localparam logic [PIDX_W-1:0] LAST_PASS = PIDX_W'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [1:0]         r_vec;        // {X,Y}
  logic [CNT_W-1:0]   r_cnt;
  logic [PIDX_W-1:0]  r_pass_idx;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [ERR_W-1:0]   r_err_count;
  logic [6:0]         r_err_mask;
  logic [1:0]         r_fail_vec;
  logic               r_fail_valid;

  logic               w_x;
  logic               w_y;
  logic [6:0]         w_f;
  logic [6:0]         w_expected;
  logic [6:0]         w_mism;
  logic               w_check;
  logic               w_fail;
  logic               w_last;
  logic [ERR_W-1:0]   w_err_next;

  assign w_x = r_vec[1];
  assign w_y = r_vec[0];
  assign w_f = {F_xnor, F_nor, F_nand, F_not, F_xor, F_or, F_and};

  assign w_expected = {~(w_x ^ w_y), ~(w_x | w_y), ~(w_x & w_y), ~w_x,
                       w_x ^ w_y, w_x | w_y, w_x & w_y};
  assign w_mism     = w_expected ^ w_f;

  // Sample on the edge that closes the last settle cycle of the vector.
  assign w_check = (r_state == S_WAIT) && (r_cnt == LAST_CNT);
  assign w_fail  = w_check && (w_mism != 7'd0);
  assign w_last  = (r_vec == 2'd3) && (r_pass_idx == LAST_PASS);

  // Count failing vectors, not failing bits; stick at all-ones.
  assign w_err_next = (w_fail && !(&r_err_count)) ? r_err_count + ERR_W'(1) : r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= 2'd0;
      r_cnt        <= '0;
      r_pass_idx   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_err_mask   <= 7'd0;
      r_fail_vec   <= 2'd0;
      r_fail_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state      <= S_WAIT;
            r_busy       <= 1'b1;
            r_vec        <= 2'd0;
            r_cnt        <= '0;
            r_pass_idx   <= '0;
            r_pass       <= 1'b0;
            r_err_count  <= '0;
            r_err_mask   <= 7'd0;
            r_fail_vec   <= 2'd0;
            r_fail_valid <= 1'b0;
          end
        end

        S_WAIT: begin
          r_err_count <= w_err_next;
          if (w_check) begin
            r_cnt <= '0;
            if (w_fail) begin
              r_err_mask <= r_err_mask | w_mism;
              if (!r_fail_valid) begin
                r_fail_vec   <= r_vec;
                r_fail_valid <= 1'b1;
              end
            end
            if (w_last) begin
              // pass uses the post-check count so the final vector is included.
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
              r_vec   <= 2'd0;
            end else begin
              r_vec <= r_vec + 2'd1;
              if (r_vec == 2'd3) begin
                r_pass_idx <= r_pass_idx + PIDX_W'(1);
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign X          = r_vec[1];
  assign Y          = r_vec[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err_count;
  assign err_mask   = r_err_mask;
  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances with different SETTLE/PASSES/ERR_W share a
// fault-injecting gate model; table vectors, hand sequences and randomized faults are checked.
module tb_gate_sweep_checker;

  localparam int S0 = 2, P0 = 1, E0 = 8;
  localparam int S1 = 3, P1 = 3, E1 = 8;
  localparam int S2 = 1, P2 = 2, E2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [2:0]           start, x, y, busy, done, pass, fvld;
  logic [2:0][6:0]      f;
  logic [2:0][6:0]      emask;
  logic [2:0][1:0]      fvec;
  logic [7:0]           ecnt0, ecnt1;
  logic [1:0]           ecnt2;

  // Gate block model: correct truth table, optional stuck-at-0 bits, per-vector flips.
  logic [6:0] force0;
  logic [6:0] xm [4];

  int ncmp = 0;
  int nfail = 0;

  // Truth table rows {xnor,nor,nand,not,xor,or,and} indexed by {X,Y}.
  function automatic logic [6:0] good(input logic [1:0] v);
    case (v)
      2'd0:    good = 7'b1111000;
      2'd1:    good = 7'b0011110;
      2'd2:    good = 7'b0010110;
      default: good = 7'b1000011;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      f[i] = (good({x[i], y[i]}) & ~force0) ^ xm[{x[i], y[i]}];
    end
  end

  gate_sweep_checker #(.SETTLE(S0), .PASSES(P0), .ERR_W(E0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .X(x[0]), .Y(y[0]),
    .F_and(f[0][0]), .F_or(f[0][1]), .F_xor(f[0][2]), .F_not(f[0][3]),
    .F_nand(f[0][4]), .F_nor(f[0][5]), .F_xnor(f[0][6]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(ecnt0),
    .err_mask(emask[0]), .fail_vec(fvec[0]), .fail_valid(fvld[0]));

  gate_sweep_checker #(.SETTLE(S1), .PASSES(P1), .ERR_W(E1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .X(x[1]), .Y(y[1]),
    .F_and(f[1][0]), .F_or(f[1][1]), .F_xor(f[1][2]), .F_not(f[1][3]),
    .F_nand(f[1][4]), .F_nor(f[1][5]), .F_xnor(f[1][6]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(ecnt1),
    .err_mask(emask[1]), .fail_vec(fvec[1]), .fail_valid(fvld[1]));

  gate_sweep_checker #(.SETTLE(S2), .PASSES(P2), .ERR_W(E2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .X(x[2]), .Y(y[2]),
    .F_and(f[2][0]), .F_or(f[2][1]), .F_xor(f[2][2]), .F_not(f[2][3]),
    .F_nand(f[2][4]), .F_nor(f[2][5]), .F_xnor(f[2][6]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(ecnt2),
    .err_mask(emask[2]), .fail_vec(fvec[2]), .fail_valid(fvld[2]));

  function automatic int s_of(input int d);
    return (d == 0) ? S0 : (d == 1) ? S1 : S2;
  endfunction
  function automatic int p_of(input int d);
    return (d == 0) ? P0 : (d == 1) ? P1 : P2;
  endfunction
  function automatic int e_of(input int d);
    return (d == 0) ? E0 : (d == 1) ? E1 : E2;
  endfunction
  function automatic logic [7:0] ecnt(input int d);
    return (d == 0) ? ecnt0 : (d == 1) ? ecnt1 : {6'd0, ecnt2};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, exp);
    end
  endtask

  // Reference: every pass visits all four vectors; tally failing vectors and gates.
  task automatic model(input int passes, input int ew, output logic [7:0] ec,
                       output logic [6:0] mk, output logic [1:0] fv,
                       output logic fval, output logic ps);
    int cnt;
    logic [6:0] m;
    cnt = 0; mk = 7'd0; fv = 2'd0; fval = 1'b0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        m = ((good(2'(v)) & ~force0) ^ xm[v]) ^ good(2'(v));
        if (m != 7'd0) begin
          cnt++;
          mk |= m;
          if (!fval) begin
            fv = 2'(v);
            fval = 1'b1;
          end
        end
      end
    end
    ec = 8'((cnt > (1 << ew) - 1) ? (1 << ew) - 1 : cnt);
    ps = (cnt == 0);
  endtask

  // Called at the negedge right after the accept edge; returns cycles until done seen.
  task automatic sweep(input int d, input int repulse, output int k);
    int lat;
    lat = 4 * p_of(d) * s_of(d);
    k = 0;
    while (!done[d] && k < lat + 20) begin
      if (k < lat) begin
        chk("xy_seq", 32'({x[d], y[d]}), 32'((k / s_of(d)) % 4));
        chk("busy_run", 32'(busy[d]), 32'd1);
      end
      if (repulse != 0) start[d] = (k == 3);
      @(negedge clk);
      k++;
    end
    start[d] = 1'b0;
    chk("latency", 32'(k), 32'(lat));
  endtask

  task automatic results(input int d, input logic [7:0] ec, input logic [6:0] mk,
                         input logic [1:0] fv, input logic fval, input logic ps);
    chk("done_hi", 32'(done[d]), 32'd1);
    chk("busy_at_done", 32'(busy[d]), 32'd0);
    chk("err_count", 32'(ecnt(d)), 32'(ec));
    chk("err_mask", 32'(emask[d]), 32'(mk));
    chk("fail_valid", 32'(fvld[d]), 32'(fval));
    if (fval) chk("fail_vec", 32'(fvec[d]), 32'(fv));
    chk("pass", 32'(pass[d]), 32'(ps));
    @(negedge clk);
    chk("done_pulse", 32'(done[d]), 32'd0);
    chk("pass_hold", 32'(pass[d]), 32'(ps));
    chk("err_hold", 32'(ecnt(d)), 32'(ec));
  endtask

  task automatic run(input int d, input int repulse, input logic [7:0] ec,
                     input logic [6:0] mk, input logic [1:0] fv, input logic fval,
                     input logic ps);
    int k;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    sweep(d, repulse, k);
    results(d, ec, mk, fv, fval, ps);
  endtask

  task automatic set_fault(input logic [6:0] f0, input logic [6:0] a, input logic [6:0] b,
                           input logic [6:0] c, input logic [6:0] e);
    force0 = f0; xm[0] = a; xm[1] = b; xm[2] = c; xm[3] = e;
  endtask

  typedef struct {
    int         d;
    logic [6:0] f0;
    logic [6:0] m0, m1, m2, m3;
    logic [7:0] ec;
    logic [6:0] mk;
    logic [1:0] fv;
    logic       fval;
    logic       ps;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int k;
    logic [7:0] ec;
    logic [6:0] mk;
    logic [1:0] fv;
    logic fval, ps;

    // Gate block clean, and-stuck-0, not=X, xor wrong at 10, all inverted (saturate), nor at 01.
    tbl[0] = '{0, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 8'd0, 7'h00, 2'd0, 1'b0, 1'b1};
    tbl[1] = '{1, 7'h01, 7'h00, 7'h00, 7'h00, 7'h00, 8'd3, 7'h01, 2'd3, 1'b1, 1'b0};
    tbl[2] = '{0, 7'h00, 7'h08, 7'h08, 7'h08, 7'h08, 8'd4, 7'h08, 2'd0, 1'b1, 1'b0};
    tbl[3] = '{2, 7'h00, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'd3, 7'h7F, 2'd0, 1'b1, 1'b0};
    tbl[4] = '{0, 7'h00, 7'h00, 7'h00, 7'h04, 7'h00, 8'd1, 7'h04, 2'd2, 1'b1, 1'b0};
    tbl[5] = '{1, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 8'd3, 7'h20, 2'd1, 1'b1, 1'b0};

    start = 3'b000;
    set_fault(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_state0", 32'({x[0], y[0], busy[0], done[0], pass[0], fvld[0], fvec[0], emask[0], ecnt0}), 32'd0);
    chk("reset_state1", 32'({busy[1], done[1], pass[1], fvld[1], ecnt1}), 32'd0);
    chk("reset_state2", 32'({busy[2], done[2], pass[2], fvld[2], ecnt2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      set_fault(tbl[i].f0, tbl[i].m0, tbl[i].m1, tbl[i].m2, tbl[i].m3);
      run(tbl[i].d, 0, tbl[i].ec, tbl[i].mk, tbl[i].fv, tbl[i].fval, tbl[i].ps);
    end

    // start re-pulsed mid-run must not change timing or results.
    set_fault(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    run(0, 1, 8'd0, 7'd0, 2'd0, 1'b0, 1'b1);

    // start held high: back-to-back runs, results cleared at the second accept.
    set_fault(7'h00, 7'h08, 7'h08, 7'h08, 7'h08);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    sweep(0, 0, k);
    start[0] = 1'b1;
    chk("held_err", 32'(ecnt0), 32'd4);
    @(negedge clk);
    chk("held_idle_done", 32'(done[0]), 32'd0);
    chk("held_idle_busy", 32'(busy[0]), 32'd0);
    chk("held_idle_err", 32'(ecnt0), 32'd4);
    @(negedge clk);
    start[0] = 1'b0;
    chk("held_restart_busy", 32'(busy[0]), 32'd1);
    chk("held_cleared", 32'({ecnt0, emask[0], fvld[0], pass[0]}), 32'd0);
    set_fault(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    sweep(0, 0, k);
    results(0, 8'd0, 7'd0, 2'd0, 1'b0, 1'b1);

    // Reset during vector 2 with an error already logged.
    set_fault(7'h00, 7'h01, 7'h00, 7'h00, 7'h00);
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2 * S0) @(negedge clk);
    chk("pre_reset_vec", 32'({x[0], y[0]}), 32'd2);
    chk("pre_reset_err", 32'(ecnt0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({x[0], y[0], busy[0], done[0], pass[0], fvld[0], fvec[0], emask[0], ecnt0}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    for (int c = 0; c < 4 * S0 * P0 + 4; c++) begin
      @(negedge clk);
      if (done[0] || busy[0]) k++;
    end
    chk("no_done_after_abort", 32'(k), 32'd0);
    set_fault(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);
    run(0, 0, 8'd0, 7'd0, 2'd0, 1'b0, 1'b1);

    // Randomized faults against the reference tally.
    for (int it = 0; it < 24; it++) begin
      int d;
      d = $urandom_range(0, 2);
      for (int v = 0; v < 4; v++) begin
        xm[v] = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
      end
      force0 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'd0;
      model(p_of(d), e_of(d), ec, mk, fv, fval, ps);
      run(d, int'($urandom_range(0, 1)), ec, mk, fv, fval, ps);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
